// File: rtl/simd_lane_sum.sv
// rtl/simd_lane_sum.sv - per-lane unsigned adder with accumulate, cascade and sticky overflow
// Optional saturation on overflow is enabled by defining SIMD_LANE_SUM_SAT_EN.
module simd_lane_sum #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 12,
  parameter int ADD_CASCADE = 0,
  parameter int INPUT_REG   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*WIDTH-1:0]     a_in,
  input  logic [LANES*WIDTH-1:0]     b_in,
  input  logic [LANES*(WIDTH+1)-1:0] casc_in,
  input  logic                       valid_in,
  input  logic                       acc_en,
  input  logic                       acc_clr,
  output logic [LANES*(WIDTH+1)-1:0] sum,
  output logic [LANES*(WIDTH+1)-1:0] casc_out,
  output logic                       valid_out,
  output logic [LANES-1:0]           ovf
);

  localparam int SW = WIDTH + 1;
  localparam int RW = WIDTH + 3;

  logic [LANES*WIDTH-1:0] a_s;
  logic [LANES*WIDTH-1:0] b_s;
  logic [LANES*SW-1:0]    c_s;
  logic                   acc_en_s;
  logic                   valid_s;

  // acc_clr bypasses this stage so a clear always acts on the adder stage at once.
  generate
    if (INPUT_REG != 0) begin : g_in_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_s      <= '0;
          b_s      <= '0;
          c_s      <= '0;
          acc_en_s <= 1'b0;
          valid_s  <= 1'b0;
        end else begin
          a_s      <= a_in;
          b_s      <= b_in;
          c_s      <= casc_in;
          acc_en_s <= acc_en;
          valid_s  <= valid_in;
        end
      end
    end else begin : g_no_in_reg
      assign a_s      = a_in;
      assign b_s      = b_in;
      assign c_s      = casc_in;
      assign acc_en_s = acc_en;
      assign valid_s  = valid_in;
    end
  endgenerate

  logic [LANES*SW-1:0] sum_nxt;
  logic [LANES-1:0]    lane_ovf;
  logic [RW-1:0]       r;

  always_comb begin
    sum_nxt  = '0;
    lane_ovf = '0;
    r        = '0;
    for (int i = 0; i < LANES; i++) begin
      r = RW'(a_s[i*WIDTH +: WIDTH]) + RW'(b_s[i*WIDTH +: WIDTH]);
      if (ADD_CASCADE != 0) r = r + RW'(c_s[i*SW +: SW]);
      // A clear coinciding with a sample zeroes the feedback term for that sample.
      if (acc_en_s && !acc_clr) r = r + RW'(sum[i*SW +: SW]);
      lane_ovf[i] = (r[RW-1:SW] != '0);
`ifdef SIMD_LANE_SUM_SAT_EN
      sum_nxt[i*SW +: SW] = lane_ovf[i] ? {SW{1'b1}} : r[SW-1:0];
`else
      sum_nxt[i*SW +: SW] = r[SW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      ovf       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_s;
      if (valid_s) begin
        sum <= sum_nxt;
        ovf <= (acc_clr ? '0 : ovf) | lane_ovf;
      end else if (acc_clr) begin
        sum <= '0;
        ovf <= '0;
      end
    end
  end

  assign casc_out = sum;

endmodule

// File: tb/tb_simd_lane_sum.sv
// tb/tb_simd_lane_sum.sv - directed self-checking bench for simd_lane_sum
module tb_simd_lane_sum;

`ifdef SIMD_LANE_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  logic [47:0] a0, b0, a1, b1;
  logic [51:0] c0, c1;
  logic        v0, ae0, ac0, v1, ae1, ac1;
  logic [51:0] sum0, co0, sum1, co1;
  logic        vo0, vo1;
  logic [3:0]  ovf0, ovf1;

  always #5 clk = ~clk;

  simd_lane_sum #(.LANES(4), .WIDTH(12), .ADD_CASCADE(0), .INPUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a_in(a0), .b_in(b0), .casc_in(c0),
    .valid_in(v0), .acc_en(ae0), .acc_clr(ac0),
    .sum(sum0), .casc_out(co0), .valid_out(vo0), .ovf(ovf0));

  simd_lane_sum #(.LANES(4), .WIDTH(12), .ADD_CASCADE(1), .INPUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_in(a1), .b_in(b1), .casc_in(c1),
    .valid_in(v1), .acc_en(ae1), .acc_clr(ac1),
    .sum(sum1), .casc_out(co1), .valid_out(vo1), .ovf(ovf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a0 = '0; b0 = '0; c0 = '0; v0 = 0; ae0 = 0; ac0 = 0;
    a1 = '0; b1 = '0; c1 = '0; v1 = 0; ae1 = 0; ac1 = 0;
    rst_n = 1'b0;
    tick();
    total++; if ({sum0, vo0, ovf0} !== 57'd0) begin bad++; $display("FAIL reset_dut0 got=%h exp=0", {sum0, vo0, ovf0}); end
    total++; if ({sum1, co1, vo1, ovf1} !== 109'd0) begin bad++; $display("FAIL reset_dut1 got=%h exp=0", {sum1, co1, vo1, ovf1}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    a0 = {12'h001, 12'h001, 12'h001, 12'hFFF};
    b0 = {12'h002, 12'h002, 12'h002, 12'hFFF};
    v0 = 1; ae0 = 0;
    tick();
    v0 = 0;
    total++; if (sum0 !== {13'h0003, 13'h0003, 13'h0003, 13'h1FFE}) begin bad++; $display("FAIL basic_sum got=%h exp=%h", sum0, {13'h0003, 13'h0003, 13'h0003, 13'h1FFE}); end
    total++; if (vo0 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", vo0); end
    total++; if (ovf0 !== 4'b0000) begin bad++; $display("FAIL basic_ovf got=%b exp=0000", ovf0); end
    total++; if (co0 !== {13'h0003, 13'h0003, 13'h0003, 13'h1FFE}) begin bad++; $display("FAIL basic_casc got=%h", co0); end
    tick();
    total++; if (vo0 !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", vo0); end
    total++; if (sum0 !== {13'h0003, 13'h0003, 13'h0003, 13'h1FFE}) begin bad++; $display("FAIL basic_hold got=%h", sum0); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp [3];
    exp[0] = 13'h1000;
    exp[1] = SAT ? 13'h1FFF : 13'h0000;
    exp[2] = SAT ? 13'h1FFF : 13'h1000;
    ac0 = 1; v0 = 0;
    tick();
    total++; if ({sum0, ovf0, vo0} !== 57'd0) begin bad++; $display("FAIL clear_idle got=%h exp=0", {sum0, ovf0, vo0}); end
    ac0 = 0;
    a0 = {36'h0, 12'h800}; b0 = {36'h0, 12'h800}; ae0 = 1; v0 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (sum0 !== {39'h0, exp[k]}) begin bad++; $display("FAIL acc_step%0d got=%h exp=%h", k, sum0, exp[k]); end
      total++; if (ovf0 !== ((k == 0) ? 4'b0000 : 4'b0001)) begin bad++; $display("FAIL acc_ovf%0d got=%b", k, ovf0); end
      total++; if (vo0 !== 1'b1) begin bad++; $display("FAIL acc_valid%0d got=%b exp=1", k, vo0); end
    end
    v0 = 0;
    tick();
    total++; if ({sum0, ovf0, vo0} !== {39'h0, exp[2], 4'b0001, 1'b0}) begin bad++; $display("FAIL acc_hold got=%h", {sum0, ovf0, vo0}); end
  endtask

  task automatic test_clear_with_valid();
    a0 = {36'h0, 12'h080}; b0 = {36'h0, 12'h080}; ae0 = 0; v0 = 1;
    tick();
    total++; if ({sum0, ovf0} !== {39'h0, 13'h0100, 4'b0001}) begin bad++; $display("FAIL pre_clear got=%h", {sum0, ovf0}); end
    a0 = {36'h0, 12'h005}; b0 = {36'h0, 12'h003}; ae0 = 1; ac0 = 1; v0 = 1;
    tick();
    ac0 = 0; v0 = 0; ae0 = 0;
    total++; if (sum0 !== {39'h0, 13'h0008}) begin bad++; $display("FAIL clr_valid_sum got=%h exp=0008", sum0); end
    total++; if ({ovf0, vo0} !== 5'b00001) begin bad++; $display("FAIL clr_valid_flags got=%b exp=00001", {ovf0, vo0}); end
  endtask

  task automatic test_cascade();
    a1 = {12'h7FF, 36'h0}; b1 = {12'h7FF, 36'h0}; c1 = {13'h1000, 39'h0}; v1 = 1; ae1 = 0;
    tick();
    a1 = '0; b1 = '0; c1 = '0; v1 = 0;
    total++; if (vo1 !== 1'b0) begin bad++; $display("FAIL casc_early got=%b exp=0", vo1); end
    tick();
    total++; if ({vo1, sum1} !== {1'b1, 13'h1FFE, 39'h0}) begin bad++; $display("FAIL casc_sum got=%h", {vo1, sum1}); end
    total++; if (co1 !== {13'h1FFE, 39'h0}) begin bad++; $display("FAIL casc_out got=%h", co1); end
    // held sample in the input register must survive a clear arriving behind it
    a1 = {36'h0, 12'h003}; b1 = {36'h0, 12'h004}; ae1 = 1; v1 = 1;
    tick();
    a1 = '0; b1 = '0; v1 = 0; ae1 = 0; ac1 = 1;
    tick();
    ac1 = 0;
    total++; if ({vo1, sum1, ovf1} !== {1'b1, 39'h0, 13'h0007, 4'b0000}) begin bad++; $display("FAIL inreg_clr got=%h", {vo1, sum1, ovf1}); end
  endtask

  task automatic test_reset_mid();
    ac0 = 1; tick(); ac0 = 0;
    a0 = {36'h0, 12'h100}; b0 = {36'h0, 12'h023}; ae0 = 0; v0 = 1;
    tick();
    total++; if (sum0 !== {39'h0, 13'h0123}) begin bad++; $display("FAIL mid_pre got=%h exp=0123", sum0); end
    a0 = {36'h0, 12'h100}; b0 = {36'h0, 12'h100}; ae0 = 1; v0 = 1;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({sum0, co0, vo0, ovf0} !== 109'd0) begin bad++; $display("FAIL mid_async got=%h exp=0", {sum0, vo0, ovf0}); end
    a0 = {36'h0, 12'h001}; b0 = {36'h0, 12'h001};
    #2 rst_n = 1'b1;
    tick();
    v0 = 0; ae0 = 0;
    total++; if ({vo0, sum0} !== {1'b1, 39'h0, 13'h0002}) begin bad++; $display("FAIL mid_after got=%h", {vo0, sum0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clear_with_valid();
    test_cascade();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
